cap_core: RTL

//  Parametrised multi-cycle processor core; next generation of the CAP17 CPU.

---
 rtl/cap_core_pkg.sv | 37 +++
 rtl/cap_alu.sv | 78 +++++++
 rtl/cap_core.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/cap_core_pkg.sv
// cap_core shared constants: opcodes, FSM states, instruction fields.
// Optional multiplier/HI support is selected by the CAP_MUL_EN macro.
package cap_core_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_LD   = 4'h2;
  localparam logic [3:0] OP_ST   = 4'h3;
  localparam logic [3:0] OP_ADD  = 4'h4;
  localparam logic [3:0] OP_SUB  = 4'h5;
  localparam logic [3:0] OP_AND  = 4'h6;
  localparam logic [3:0] OP_OR   = 4'h7;
  localparam logic [3:0] OP_XOR  = 4'h8;
  localparam logic [3:0] OP_SHL  = 4'h9;
  localparam logic [3:0] OP_SHR  = 4'hA;
  localparam logic [3:0] OP_MUL  = 4'hB;
  localparam logic [3:0] OP_JMP  = 4'hC;
  localparam logic [3:0] OP_JZ   = 4'hD;
  localparam logic [3:0] OP_MFHI = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_HALT   = 3'd4;

  localparam int OP_HI    = 15;
  localparam int OP_LO    = 12;
  localparam int RD_HI    = 11;
  localparam int RD_LO    = 8;
  localparam int RS_HI    = 7;
  localparam int RS_LO    = 4;
  localparam int IMM8_HI  = 7;
  localparam int IMM12_HI = 11;

endpackage

// File: rtl/cap_alu.sv
// cap_core combinational ALU: add/sub/logic/shift and flags.
// The unsigned multiplier and HI output exist only with CAP_MUL_EN.
module cap_alu
  import cap_core_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [3:0]        op,
  output logic [DATA_W-1:0] res,
`ifdef CAP_MUL_EN
  output logic [DATA_W-1:0] hi,
`endif
  output logic              z,
  output logic              n,
  output logic              c,
  output logic              v
);

  localparam int M = DATA_W - 1;

  logic [DATA_W:0] w_add;
  logic [DATA_W:0] w_sub;

  assign w_add = {1'b0, a} + {1'b0, b};
  assign w_sub = {1'b0, a} - {1'b0, b};

`ifdef CAP_MUL_EN
  logic [2*DATA_W-1:0] w_prod;
  assign w_prod = a * b;
`endif

  // Result and flag selection by opcode
  always_comb begin
    res = a;
`ifdef CAP_MUL_EN
    hi  = '0;
`endif
    c   = 1'b0;
    v   = 1'b0;
    case (op)
      OP_ADD: begin
        res = w_add[M:0];
        c   = w_add[DATA_W];
        v   = (a[M] == b[M]) && (w_add[M] != a[M]);
      end
      OP_SUB: begin
        res = w_sub[M:0];
        c   = w_sub[DATA_W];
        v   = (a[M] != b[M]) && (w_sub[M] != a[M]);
      end
      OP_AND: res = a & b;
      OP_OR:  res = a | b;
      OP_XOR: res = a ^ b;
      OP_SHL: begin
        res = {a[M-1:0], 1'b0};
        c   = a[M];
      end
      OP_SHR: begin
        res = {1'b0, a[M:1]};
        c   = a[0];
      end
`ifdef CAP_MUL_EN
      OP_MUL: begin
        res = w_prod[M:0];
        hi  = w_prod[2*DATA_W-1:DATA_W];
        c   = |w_prod[2*DATA_W-1:DATA_W];
        v   = |w_prod[2*DATA_W-1:DATA_W];
      end
`endif
      default: ;
    endcase
    z = (res == '0);
    n = res[M];
  end

endmodule

// File: rtl/cap_core.sv
// cap_core: multi-cycle CAP17-family core with req/ack memory bus.
// Define CAP_MUL_EN to build MUL/MFHI and the HI register.
module cap_core
  import cap_core_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 11,
  parameter int NREG   = 4
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              halted,
  output logic [ADDR_W-1:0] pc_out
);

  localparam int IW = $clog2(NREG);

  // Fold an out-of-range index back into the file for non-power-of-2 NREG
  function automatic logic [IW-1:0] reg_idx(input logic [IW-1:0] f);
    logic [IW:0] t;
    t = {1'b0, f};
    if (t >= (IW+1)'(NREG)) t = t - (IW+1)'(NREG);
    return t[IW-1:0];
  endfunction

  logic [2:0]        r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [15:0]       r_ir;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [DATA_W-1:0] r_regs [NREG];
  logic              r_z, r_n, r_c, r_v;
  logic              r_req;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_halted;
`ifdef CAP_MUL_EN
  logic [DATA_W-1:0] r_hi;
  logic [DATA_W-1:0] w_hi;
`endif

  logic [3:0]        w_op;
  logic [IW-1:0]     w_rd;
  logic [IW-1:0]     w_rs;
  logic [ADDR_W-1:0] w_imm12;
  logic [DATA_W-1:0] w_imm8;
  logic [DATA_W-1:0] w_res;
  logic              w_z, w_n, w_c, w_v;

  assign w_op    = r_ir[OP_HI:OP_LO];
  assign w_rd    = reg_idx(IW'(r_ir[RD_HI:RD_LO]));
  assign w_rs    = reg_idx(IW'(r_ir[RS_HI:RS_LO]));
  assign w_imm12 = ADDR_W'(r_ir[IMM12_HI:0]);
  assign w_imm8  = DATA_W'(r_ir[IMM8_HI:0]);

  cap_alu #(.DATA_W(DATA_W)) u_alu (
    .a   (r_a),
    .b   (r_b),
    .op  (w_op),
    .res (w_res),
`ifdef CAP_MUL_EN
    .hi  (w_hi),
`endif
    .z   (w_z),
    .n   (w_n),
    .c   (w_c),
    .v   (w_v)
  );

  // Control FSM, register file, flags and registered bus outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_FETCH;
      r_pc     <= '0;
      r_ir     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_z      <= 1'b0;
      r_n      <= 1'b0;
      r_c      <= 1'b0;
      r_v      <= 1'b0;
      r_req    <= 1'b0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_halted <= 1'b0;
`ifdef CAP_MUL_EN
      r_hi     <= '0;
`endif
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (!r_req) begin
            r_req  <= 1'b1;
            r_we   <= 1'b0;
            r_addr <= r_pc;
          end else if (mem_ack) begin
            r_req   <= 1'b0;
            r_ir    <= mem_rdata[15:0];
            r_pc    <= r_pc + ADDR_W'(1);
            r_state <= S_DECODE;
          end
        end
        S_DECODE: begin
          r_a     <= r_regs[w_rd];
          r_b     <= r_regs[w_rs];
          r_state <= S_EXEC;
        end
        S_EXEC: begin
          r_state <= S_FETCH;
          case (w_op)
            OP_LDI: r_regs[w_rd] <= w_imm8;
            OP_LD, OP_ST: r_state <= S_MEM;
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_XOR, OP_SHL, OP_SHR: begin
              r_regs[w_rd] <= w_res;
              r_z <= w_z;
              r_n <= w_n;
              r_c <= w_c;
              r_v <= w_v;
            end
`ifdef CAP_MUL_EN
            OP_MUL: begin
              r_regs[w_rd] <= w_res;
              r_hi <= w_hi;
              r_z  <= w_z;
              r_n  <= w_n;
              r_c  <= w_c;
              r_v  <= w_v;
            end
            OP_MFHI: r_regs[w_rd] <= r_hi;
`endif
            OP_JMP: r_pc <= w_imm12;
            OP_JZ: if (r_z) r_pc <= w_imm12;
            OP_HALT: begin
              r_state  <= S_HALT;
              r_halted <= 1'b1;
            end
            default: ;
          endcase
        end
        S_MEM: begin
          if (!r_req) begin
            r_req   <= 1'b1;
            r_we    <= (w_op == OP_ST);
            r_addr  <= ADDR_W'(r_b);
            r_wdata <= r_a;
          end else if (mem_ack) begin
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_state <= S_FETCH;
            if (w_op == OP_LD) r_regs[w_rd] <= mem_rdata;
          end
        end
        S_HALT: ;
        default: r_state <= S_FETCH;
      endcase
    end
  end

  assign mem_req   = r_req;
  assign mem_we    = r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign halted    = r_halted;
  assign pc_out    = r_pc;

endmodule
